// File: rtl/afc_pkg.sv
// Shared types and sizing helpers for the automatic frequency calibrator.
// The sequencer, its window timer and the bench all size themselves from these.
package afc_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StCount  = 3'd2,
    StSettle = 3'd3,
    StDecide = 3'd4,
    StDone   = 3'd5,
    StFail   = 3'd6
  } afc_state_e;

  typedef enum logic {
    PhSar    = 1'b0,
    PhLinear = 1'b1
  } afc_phase_e;

  localparam int unsigned TrimWidthDef    = 6;
  localparam int unsigned WindowCyclesDef = 256;
  localparam int unsigned SettleCyclesDef = 8;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int unsigned bits_for_count(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The timer loads duration-1, so the longest duration sets the width.
  function automatic int unsigned timer_width(input int unsigned window,
                                              input int unsigned settle);
    int unsigned longest;
    longest = (window > settle) ? window : settle;
    return bits_for_count(longest);
  endfunction

  // SAR starting point: only the top trim bit set.
  function automatic int unsigned trim_mid(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/afc_window_timer.sv
// Load-and-count-down timer shared by the measurement window and settle delay.
// After a load of N-1, 'expired' pulses on the N-th cycle following the load.
module afc_window_timer #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic            expired
);

  logic [CntW-1:0] cnt_q;
  logic            running_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (load) begin
      cnt_q     <= load_val;
      running_q <= 1'b1;
    end else if (expired) begin
      running_q <= 1'b0;
    end else if (running_q) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_comb begin
    expired = running_q && (cnt_q == '0);
  end

endmodule

// File: rtl/afc_cal_sequencer.sv
// Calibration controller: runs count windows, reads the comparator flags and drives the
// oscillator trim by SAR search followed by a bounded +/-1 linear refine.
module afc_cal_sequencer
  import afc_pkg::*;
#(
  parameter int unsigned TRIM_WIDTH    = TrimWidthDef,
  parameter int unsigned WINDOW_CYCLES = WindowCyclesDef,
  parameter int unsigned SETTLE_CYCLES = SettleCyclesDef,
  parameter int unsigned MAX_STEPS     = 8,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ref_faster,
  input  logic                  div_faster,
  input  logic                  equal,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  output logic [TRIM_WIDTH-1:0] trim_code,
  output logic                  busy,
  output logic                  cal_done,
  output logic                  cal_fail,
  output logic [7:0]            meas_count
);

  localparam int unsigned TimerW = timer_width(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam int unsigned IdxW   = bits_for_count(TRIM_WIDTH);
  localparam int unsigned StepW  = bits_for_count(MAX_STEPS + 1);
  localparam int unsigned RetryW = bits_for_count(MAX_RETRY + 1);

  localparam logic [TRIM_WIDTH-1:0] TrimMid = TRIM_WIDTH'(trim_mid(TRIM_WIDTH));
  localparam logic [TRIM_WIDTH-1:0] TrimMax = {TRIM_WIDTH{1'b1}};
  localparam logic [IdxW-1:0]       IdxTop  = IdxW'(TRIM_WIDTH - 1);

  afc_state_e            state_q, state_d;
  afc_phase_e            phase_q, phase_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic [StepW-1:0]      steps_q, steps_d;
  logic [RetryW-1:0]     retry_q, retry_d;
  logic [TRIM_WIDTH-1:0] trim_q, trim_d;
  logic [7:0]            meas_q, meas_d;

  logic cnt_clear_q, cnt_clear_d;
  logic cnt_enable_q, cnt_enable_d;
  logic busy_q, busy_d;
  logic cal_done_q, cal_done_d;
  logic cal_fail_q, cal_fail_d;

  logic              timer_load;
  logic [TimerW-1:0] timer_val;
  logic              timer_expired;

  // The timer is armed while in CLEAR for the window, and at the end of the window for settle.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = TimerW'(WINDOW_CYCLES - 1);
    if (state_q == StClear) begin
      timer_load = 1'b1;
    end else if (state_q == StCount && timer_expired) begin
      timer_load = 1'b1;
      timer_val  = TimerW'(SETTLE_CYCLES - 1);
    end
  end

  afc_window_timer #(
    .CntW (TimerW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= PhSar;
      bit_idx_q    <= IdxTop;
      steps_q      <= '0;
      retry_q      <= '0;
      trim_q       <= TrimMid;
      meas_q       <= '0;
      cnt_clear_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      cal_done_q   <= 1'b0;
      cal_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_idx_q    <= bit_idx_d;
      steps_q      <= steps_d;
      retry_q      <= retry_d;
      trim_q       <= trim_d;
      meas_q       <= meas_d;
      cnt_clear_q  <= cnt_clear_d;
      cnt_enable_q <= cnt_enable_d;
      busy_q       <= busy_d;
      cal_done_q   <= cal_done_d;
      cal_fail_q   <= cal_fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    steps_d   = steps_q;
    retry_d   = retry_q;
    trim_d    = trim_q;
    meas_d    = meas_q;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          state_d   = StClear;
          phase_d   = PhSar;
          bit_idx_d = IdxTop;
          steps_d   = '0;
          retry_d   = '0;
          trim_d    = TrimMid;
          meas_d    = '0;
        end
      end
      StClear: state_d = StCount;
      StCount: begin
        if (timer_expired) state_d = StSettle;
      end
      StSettle: begin
        if (timer_expired) state_d = StDecide;
      end
      StDecide: begin
        meas_d = (meas_q == 8'hff) ? meas_q : meas_q + 8'd1;
        if (equal) begin
          state_d = StDone;
        end else if (!ref_faster && !div_faster) begin
          // Inconclusive: re-measure the same trim until the retry budget runs out.
          if (retry_q == RetryW'(MAX_RETRY)) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StClear;
          end
        end else if (phase_q == PhSar) begin
          retry_d         = '0;
          state_d         = StClear;
          trim_d[bit_idx_q] = ref_faster;
          if (bit_idx_q != '0) begin
            trim_d[bit_idx_q - IdxW'(1)] = 1'b1;
            bit_idx_d                    = bit_idx_q - IdxW'(1);
          end else begin
            phase_d = PhLinear;
            steps_d = '0;
          end
        end else begin
          retry_d = '0;
          if (steps_q == StepW'(MAX_STEPS)) begin
            state_d = StFail;
          end else if (ref_faster) begin
            if (trim_q == TrimMax) begin
              state_d = StFail;
            end else begin
              trim_d  = trim_q + TRIM_WIDTH'(1);
              steps_d = steps_q + StepW'(1);
              state_d = StClear;
            end
          end else begin
            if (trim_q == '0) begin
              state_d = StFail;
            end else begin
              trim_d  = trim_q - TRIM_WIDTH'(1);
              steps_d = steps_q + StepW'(1);
              state_d = StClear;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    cnt_clear_d  = (state_d == StClear);
    cnt_enable_d = (state_d == StCount);
    cal_done_d   = (state_d == StDone);
    cal_fail_d   = (state_d == StFail);
    busy_d       = !(state_d inside {StIdle, StDone, StFail});
  end

  assign cnt_clear  = cnt_clear_q;
  assign cnt_enable = cnt_enable_q;
  assign trim_code  = trim_q;
  assign busy       = busy_q;
  assign cal_done   = cal_done_q;
  assign cal_fail   = cal_fail_q;
  assign meas_count = meas_q;

endmodule
